usbdev_linkstate_seq: RTL and testbench
=======================================

// Module: usbdev_linkstate_seq
// PURPOSE
//  Hardware sequencer that owns the usbdev PHY pin-override path: debounces VBUS sense, gates pullup
//  connect, and drives timed bus patterns (resume-K, SE0+J) that used to need SW bit-banging.
//  Sits between usbdev core/CSRs and the IO mux; its drive_* outputs feed the mux override inputs.
// PARAMETERS
//  DebounceCycles  16     consecutive stable cycles needed to change vbus_valid_o (>=2)
//  TimerW          16     width of the pattern timer
//  ResumeCycles    20000  cycles of K driven for a resume (1..2**TimerW-1)
//  Se0Cycles       48     cycles of SE0 driven for an SE0 request (1..2**TimerW-1)
//  JCycles         4      cycles of J driven after SE0 before release (1..2**TimerW-1)
// PORTS
//  clk_i           in   1  clock; single domain
//  rst_i           in   1  reset; asynchronous, active-high
//  pwr_sense_i     in   1  VBUS sense, already 2-flop synchronized
//  connect_req_i   in   1  level: SW wants device attached
//  pin_flip_i      in   1  level: swap D+/D- roles (pullup and K/J polarity)
//  bus_idle_i      in   1  level: received line is J/idle
//  resume_req_i    in   1  pulse: drive resume K
//  se0_req_i       in   1  pulse: drive SE0 then J
//  drive_en_o      out  1  override enable to IO mux
//  drive_dp_o      out  1  D+ value
//  drive_dn_o      out  1  D- value
//  drive_d_o       out  1  differential data value (= drive_dp_o)
//  drive_se0_o     out  1  SE0 indication
//  drive_oe_o      out  1  output enable
//  dp_pullup_en_o  out  1  D+ pullup
//  dn_pullup_en_o  out  1  D- pullup
//  rx_enable_o     out  1  differential receiver enable (= vbus_valid_o)
//  vbus_valid_o    out  1  debounced VBUS
//  busy_o          out  1  state in WAIT_IDLE/DRIVE_K/DRIVE_SE0/DRIVE_J
//  done_o          out  1  pulse: pattern completed normally
//  err_o           out  1  pulse: request rejected or sequence aborted
// BEHAVIOUR
//  - All outputs are registered. Reset value of every output is 0; state = DISCONNECTED.
//  - Debounce: counter clears whenever pwr_sense_i == vbus_valid_o. vbus_valid_o toggles on the
//    cycle the counter reaches DebounceCycles, and the counter then clears. A glitch shorter than
//    DebounceCycles causes no change.
//  - attach = connect_req_i & vbus_valid_o.
//  - Pullups: dp_pullup_en_o = attach & ~pin_flip_i; dn_pullup_en_o = attach & pin_flip_i.
//    Both update one cycle after their inputs.
//  - Line encoding (pin_flip_i = 0): J = dp1/dn0; K = dp0/dn1; SE0 = dp0/dn0 with se0 = 1.
//    pin_flip_i = 1 swaps dp/dn for J and K.
//    drive_oe_o = drive_en_o = 1 in DRIVE_* states only.
//  - FSM:
//    DISCONNECTED -> CONNECTED when attach.
//    CONNECTED, resume_req_i: -> DRIVE_K if bus_idle_i, else -> WAIT_IDLE.
//    CONNECTED, se0_req_i: -> DRIVE_SE0.
//    WAIT_IDLE -> DRIVE_K when bus_idle_i.
//    DRIVE_K (ResumeCycles) -> CONNECTED, with done_o.
//    DRIVE_SE0 (Se0Cycles) -> DRIVE_J.
//    DRIVE_J (JCycles) -> CONNECTED, with done_o.
//  - Timer: loads N-1 on state entry and counts down. The state exits on the cycle the timer is 0,
//    so the pattern is on the pins for exactly N cycles.
//  - Latency: a request sampled in CONNECTED with bus idle at cycle t puts the pattern on the pins
//    at t+1.
//  - Same-cycle resume_req_i and se0_req_i: resume wins; err_o pulses once for the dropped SE0.
//  - A request in any state other than CONNECTED is ignored and err_o pulses.
//    This includes a request during busy_o.
//  - attach drops in any state: go to DISCONNECTED next cycle with drive_en_o = 0.
//    If busy_o was set, err_o pulses and done_o does not.
//  - pin_flip_i change while driving: takes effect on the next cycle's pins (no abort).
//  - Async reset mid-pattern: outputs 0 immediately; no done_o or err_o.
// STRUCTURE
//  - usbdev_pkg: linkstate_e enum (DISCONNECTED, CONNECTED, WAIT_IDLE, DRIVE_K, DRIVE_SE0,
//    DRIVE_J) and a line_e encoding (J, K, SE0).
//  - Sub-module usbdev_vbus_debounce (counter + vbus_valid_o), parameterized by DebounceCycles.
//  - Parameter range checks are elaboration-time asserts.
//  - SVA: drive_en_o -> attach in the previous cycle; done_o and err_o never asserted together.
// TESTING
//  - VBUS: pwr_sense_i high 15 cycles then low -> vbus_valid_o stays 0.
//    High 16 cycles -> vbus_valid_o = 1 on cycle 16.
//    A later 10-cycle low glitch -> stays 1.
//  - Connect: connect_req_i = 1 with vbus valid -> dp_pullup_en_o = 1 next cycle, rx_enable_o = 1.
//    pin_flip_i = 1 -> dn_pullup_en_o = 1, dp_pullup_en_o = 0.
//  - Resume with ResumeCycles = 8 and bus idle: pulse at t -> dp0/dn1, oe = 1 for cycles t+1..t+8;
//    done_o at t+8; drive_en_o = 0 at t+9.
//  - SE0 (Se0Cycles = 3, JCycles = 2): se0_o = 1 for 3 cycles, then dp1/dn0 for 2 cycles, then done_o.
//    A resume_req_i during the sequence -> err_o, pattern unaffected.
//  - Resume while bus_idle_i = 0 for 5 cycles -> WAIT_IDLE, pins undriven, busy_o = 1;
//    K starts the cycle after bus_idle_i rises.
//  - Abort: connect_req_i drops mid-K -> drive_en_o = 0 and pullups = 0 next cycle; err_o = 1,
//    no done_o. Same-cycle resume + SE0 -> K driven, one err_o pulse.

Source files
------------

// File: rtl/usbdev_linkstate_seq_pkg.sv
// Shared types for the usbdev link-state sequencer: FSM states, bus line codes and the
// pin-override bundle, plus helpers that classify states and encode a line onto D+/D-.
package usbdev_linkstate_seq_pkg;

   typedef enum logic [2:0] {
      LS_DISCONNECTED,
      LS_CONNECTED,
      LS_WAIT_IDLE,
      LS_DRIVE_K,
      LS_DRIVE_SE0,
      LS_DRIVE_J
   } linkstate_e;

   typedef enum logic [1:0] {
      LINE_J,
      LINE_K,
      LINE_SE0
   } line_e;

   typedef struct packed {
      logic en;
      logic dp;
      logic dn;
      logic se0;
   } drive_t;

   function automatic logic is_busy(linkstate_e s);
      return (s == LS_WAIT_IDLE) || (s == LS_DRIVE_K) ||
             (s == LS_DRIVE_SE0) || (s == LS_DRIVE_J);
   endfunction

   // With flip set the D+/D- roles swap, so J/K polarity inverts; SE0 is symmetric.
   function automatic drive_t encode_line(line_e l, logic flip);
      drive_t d;
      d = '{en: 1'b1, dp: 1'b0, dn: 1'b0, se0: 1'b0};
      case (l)
         LINE_J:   begin d.dp = ~flip; d.dn = flip;  end
         LINE_K:   begin d.dp = flip;  d.dn = ~flip; end
         LINE_SE0: d.se0 = 1'b1;
         default:  d.en = 1'b0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/usbdev_linkstate_seq_if.sv
// Control/observe bundle between usbdev core/CSRs (master) and the link-state sequencer (slave).
// Suffixes are from the sequencer's point of view.
interface usbdev_linkstate_seq_if;
   logic pwr_sense_i;
   logic connect_req_i;
   logic pin_flip_i;
   logic bus_idle_i;
   logic resume_req_i;
   logic se0_req_i;
   logic drive_en_o;
   logic drive_dp_o;
   logic drive_dn_o;
   logic drive_d_o;
   logic drive_se0_o;
   logic drive_oe_o;
   logic dp_pullup_en_o;
   logic dn_pullup_en_o;
   logic rx_enable_o;
   logic vbus_valid_o;
   logic busy_o;
   logic done_o;
   logic err_o;

   modport slave (
      input  pwr_sense_i, connect_req_i, pin_flip_i, bus_idle_i, resume_req_i, se0_req_i,
      output drive_en_o, drive_dp_o, drive_dn_o, drive_d_o, drive_se0_o, drive_oe_o,
             dp_pullup_en_o, dn_pullup_en_o, rx_enable_o, vbus_valid_o, busy_o, done_o, err_o
   );

   modport master (
      output pwr_sense_i, connect_req_i, pin_flip_i, bus_idle_i, resume_req_i, se0_req_i,
      input  drive_en_o, drive_dp_o, drive_dn_o, drive_d_o, drive_se0_o, drive_oe_o,
             dp_pullup_en_o, dn_pullup_en_o, rx_enable_o, vbus_valid_o, busy_o, done_o, err_o
   );
endinterface

// File: rtl/usbdev_linkstate_seq_vbus_debounce.sv
// VBUS sense debouncer: valid_o follows sense_i only after DebounceCycles consecutive
// disagreeing samples; any agreeing sample restarts the count.
module usbdev_vbus_debounce #(
   parameter int unsigned DebounceCycles = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic sense_i,
   output logic valid_o
);
   localparam int unsigned CntW = $clog2(DebounceCycles + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            valid_q, valid_d;

   always_comb begin
      cnt_d   = '0;
      valid_d = valid_q;
      if (sense_i != valid_q) begin
         if (cnt_q == CntW'(DebounceCycles - 1)) begin
            valid_d = sense_i;
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign valid_o = valid_q;
endmodule

// File: rtl/usbdev_linkstate_seq.sv
// Link-state sequencer owning the usbdev pin-override path: VBUS debounce, pullup gating and
// timed resume-K / SE0+J patterns. Every output is registered from next-state values.
module usbdev_linkstate_seq
   import usbdev_linkstate_seq_pkg::*;
#(
   parameter int unsigned DebounceCycles = 16,
   parameter int unsigned TimerW         = 16,
   parameter int unsigned ResumeCycles   = 20000,
   parameter int unsigned Se0Cycles      = 48,
   parameter int unsigned JCycles        = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   usbdev_linkstate_seq_if.slave  bus
);
   localparam int unsigned TimerMax = (1 << TimerW) - 1;

   if (DebounceCycles < 2) begin : g_bad_debounce
      $error("DebounceCycles must be at least 2");
   end
   if (ResumeCycles < 1 || ResumeCycles > TimerMax) begin : g_bad_resume
      $error("ResumeCycles out of timer range");
   end
   if (Se0Cycles < 1 || Se0Cycles > TimerMax) begin : g_bad_se0
      $error("Se0Cycles out of timer range");
   end
   if (JCycles < 1 || JCycles > TimerMax) begin : g_bad_j
      $error("JCycles out of timer range");
   end

   localparam logic [TimerW-1:0] ResumeLoad = TimerW'(ResumeCycles - 1);
   localparam logic [TimerW-1:0] Se0Load    = TimerW'(Se0Cycles - 1);
   localparam logic [TimerW-1:0] JLoad      = TimerW'(JCycles - 1);

   logic vbus_valid;
   logic attach;
   logic req_any;

   usbdev_vbus_debounce #(.DebounceCycles(DebounceCycles)) u_debounce (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .sense_i (bus.pwr_sense_i),
      .valid_o (vbus_valid)
   );

   assign attach  = bus.connect_req_i & vbus_valid;
   assign req_any = bus.resume_req_i | bus.se0_req_i;

   linkstate_e        state_q, state_d;
   logic [TimerW-1:0] timer_q, timer_d;
   drive_t            drv_q, drv_d;
   logic              dp_pu_q, dp_pu_d, dn_pu_q, dn_pu_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic              err_q, err_d, err_pend_q, err_pend_d, err_evt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= LS_DISCONNECTED;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!attach) begin
         state_d = LS_DISCONNECTED;
      end else begin
         case (state_q)
            LS_DISCONNECTED: state_d = LS_CONNECTED;
            LS_CONNECTED: begin
               if (bus.resume_req_i) begin
                  state_d = bus.bus_idle_i ? LS_DRIVE_K : LS_WAIT_IDLE;
               end else if (bus.se0_req_i) begin
                  state_d = LS_DRIVE_SE0;
               end
            end
            LS_WAIT_IDLE: if (bus.bus_idle_i) state_d = LS_DRIVE_K;
            LS_DRIVE_K:   if (timer_q == '0) state_d = LS_CONNECTED;
            LS_DRIVE_SE0: if (timer_q == '0) state_d = LS_DRIVE_J;
            LS_DRIVE_J:   if (timer_q == '0) state_d = LS_CONNECTED;
            default:      state_d = LS_DISCONNECTED;
         endcase
      end

      // Reload on every state entry so a pattern always lasts exactly its N cycles.
      timer_d = timer_q;
      if (state_d != state_q) begin
         case (state_d)
            LS_DRIVE_K:   timer_d = ResumeLoad;
            LS_DRIVE_SE0: timer_d = Se0Load;
            LS_DRIVE_J:   timer_d = JLoad;
            default:      timer_d = '0;
         endcase
      end else if (timer_q != '0) begin
         timer_d = timer_q - TimerW'(1);
      end
   end

   always_comb begin
      drv_d = '0;
      case (state_d)
         LS_DRIVE_K:   drv_d = encode_line(LINE_K, bus.pin_flip_i);
         LS_DRIVE_SE0: drv_d = encode_line(LINE_SE0, bus.pin_flip_i);
         LS_DRIVE_J:   drv_d = encode_line(LINE_J, bus.pin_flip_i);
         default:      drv_d = '0;
      endcase

      dp_pu_d = attach & ~bus.pin_flip_i;
      dn_pu_d = attach & bus.pin_flip_i;
      busy_d  = is_busy(state_d);
      // Registered done lands on the final pattern cycle, so it is decided one cycle early.
      done_d  = ((state_d == LS_DRIVE_K) || (state_d == LS_DRIVE_J)) && (timer_d == '0);

      err_evt = (req_any && ((state_q != LS_CONNECTED) || !attach)) ||
                (bus.resume_req_i && bus.se0_req_i) ||
                (!attach && is_busy(state_q));
      // An error colliding with done is held back one cycle so the two never overlap.
      err_d      = (err_evt | err_pend_q) & ~done_d;
      err_pend_d = (err_evt | err_pend_q) & done_d;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         drv_q      <= '0;
         dp_pu_q    <= 1'b0;
         dn_pu_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_pend_q <= 1'b0;
      end else begin
         drv_q      <= drv_d;
         dp_pu_q    <= dp_pu_d;
         dn_pu_q    <= dn_pu_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_pend_q <= err_pend_d;
      end
   end

   assign bus.drive_en_o     = drv_q.en;
   assign bus.drive_oe_o     = drv_q.en;
   assign bus.drive_dp_o     = drv_q.dp;
   assign bus.drive_d_o      = drv_q.dp;
   assign bus.drive_dn_o     = drv_q.dn;
   assign bus.drive_se0_o    = drv_q.se0;
   assign bus.dp_pullup_en_o = dp_pu_q;
   assign bus.dn_pullup_en_o = dn_pu_q;
   assign bus.vbus_valid_o   = vbus_valid;
   assign bus.rx_enable_o    = vbus_valid;
   assign bus.busy_o         = busy_q;
   assign bus.done_o         = done_q;
   assign bus.err_o          = err_q;

   a_drive_needs_attach: assert property (@(posedge clk_i) disable iff (rst_i)
      bus.drive_en_o |-> $past(attach));
   a_done_err_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
      !(bus.done_o && bus.err_o));
endmodule

// File: tb/tb_usbdev_linkstate_seq.sv
// Directed bench for usbdev_linkstate_seq with short pattern lengths; expected values are
// hand-derived cycle by cycle, outputs sampled 1 ns after each rising edge.
module tb_usbdev_linkstate_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   usbdev_linkstate_seq_if bus();

   usbdev_linkstate_seq #(
      .DebounceCycles(16), .TimerW(16), .ResumeCycles(8), .Se0Cycles(3), .JCycles(2)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_pins(input string tag, input logic en, input logic dp, input logic dn,
                           input logic se0);
      chk({tag, ".en"},  bus.drive_en_o,  en);
      chk({tag, ".oe"},  bus.drive_oe_o,  en);
      chk({tag, ".dp"},  bus.drive_dp_o,  dp);
      chk({tag, ".d"},   bus.drive_d_o,   dp);
      chk({tag, ".dn"},  bus.drive_dn_o,  dn);
      chk({tag, ".se0"}, bus.drive_se0_o, se0);
   endtask

   initial begin
      bus.pwr_sense_i   = 1'b0;
      bus.connect_req_i = 1'b0;
      bus.pin_flip_i    = 1'b0;
      bus.bus_idle_i    = 1'b0;
      bus.resume_req_i  = 1'b0;
      bus.se0_req_i     = 1'b0;

      tick(2);
      chk_pins("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset.vbus", bus.vbus_valid_o, 1'b0);
      chk("reset.busy", bus.busy_o, 1'b0);
      chk("reset.done", bus.done_o, 1'b0);
      chk("reset.err",  bus.err_o,  1'b0);
      rst = 1'b0;
      tick(2);

      // VBUS debounce: 15 high samples are not enough, 16 are, a 10-cycle low glitch is ignored
      bus.pwr_sense_i = 1'b1;
      tick(15);
      chk("vbus.hi15", bus.vbus_valid_o, 1'b0);
      bus.pwr_sense_i = 1'b0;
      tick(1);
      chk("vbus.drop15", bus.vbus_valid_o, 1'b0);
      tick(3);
      bus.pwr_sense_i = 1'b1;
      tick(15);
      chk("vbus.hi15b", bus.vbus_valid_o, 1'b0);
      tick(1);
      chk("vbus.hi16", bus.vbus_valid_o, 1'b1);
      chk("vbus.rx_en", bus.rx_enable_o, 1'b1);
      chk("vbus.nopu", bus.dp_pullup_en_o, 1'b0);
      bus.pwr_sense_i = 1'b0;
      tick(10);
      chk("vbus.glitch", bus.vbus_valid_o, 1'b1);
      bus.pwr_sense_i = 1'b1;
      tick(20);
      chk("vbus.after", bus.vbus_valid_o, 1'b1);

      // Connect and pin flip
      bus.connect_req_i = 1'b1;
      tick(1);
      chk("conn.dp_pu", bus.dp_pullup_en_o, 1'b1);
      chk("conn.dn_pu", bus.dn_pullup_en_o, 1'b0);
      chk("conn.busy",  bus.busy_o, 1'b0);
      bus.pin_flip_i = 1'b1;
      tick(1);
      chk("flip.dp_pu", bus.dp_pullup_en_o, 1'b0);
      chk("flip.dn_pu", bus.dn_pullup_en_o, 1'b1);
      bus.pin_flip_i = 1'b0;
      tick(1);
      chk("unflip.dp_pu", bus.dp_pullup_en_o, 1'b1);

      // Resume with bus idle: K on cycles t+1..t+8, done on t+8, released on t+9
      bus.bus_idle_i   = 1'b1;
      bus.resume_req_i = 1'b1;
      tick(1);
      bus.resume_req_i = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k > 1) tick(1);
         chk_pins($sformatf("res.k%0d", k), 1'b1, 1'b0, 1'b1, 1'b0);
         chk($sformatf("res.done%0d", k), bus.done_o, (k == 8) ? 1'b1 : 1'b0);
         chk($sformatf("res.busy%0d", k), bus.busy_o, 1'b1);
         chk($sformatf("res.err%0d", k),  bus.err_o,  1'b0);
      end
      tick(1);
      chk_pins("res.end", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("res.end.done", bus.done_o, 1'b0);
      chk("res.end.busy", bus.busy_o, 1'b0);

      // SE0 x3 then J x2; a resume during SE0 is rejected without disturbing the pattern
      bus.se0_req_i = 1'b1;
      tick(1);
      bus.se0_req_i = 1'b0;
      chk_pins("se0.c1", 1'b1, 1'b0, 1'b0, 1'b1);
      bus.resume_req_i = 1'b1;
      tick(1);
      bus.resume_req_i = 1'b0;
      chk_pins("se0.c2", 1'b1, 1'b0, 1'b0, 1'b1);
      chk("se0.c2.err", bus.err_o, 1'b1);
      tick(1);
      chk_pins("se0.c3", 1'b1, 1'b0, 1'b0, 1'b1);
      chk("se0.c3.err", bus.err_o, 1'b0);
      tick(1);
      chk_pins("se0.j1", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("se0.j1.done", bus.done_o, 1'b0);
      tick(1);
      chk_pins("se0.j2", 1'b1, 1'b1, 1'b0, 1'b0);
      chk("se0.j2.done", bus.done_o, 1'b1);
      tick(1);
      chk_pins("se0.end", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("se0.end.done", bus.done_o, 1'b0);

      // Resume while bus busy: WAIT_IDLE, pins undriven, K the cycle after idle returns
      bus.bus_idle_i   = 1'b0;
      bus.resume_req_i = 1'b1;
      tick(1);
      bus.resume_req_i = 1'b0;
      chk("wait.busy1", bus.busy_o, 1'b1);
      chk("wait.en1",   bus.drive_en_o, 1'b0);
      tick(4);
      chk("wait.busy5", bus.busy_o, 1'b1);
      chk("wait.en5",   bus.drive_en_o, 1'b0);
      bus.bus_idle_i = 1'b1;
      tick(1);
      chk_pins("wait.k1", 1'b1, 1'b0, 1'b1, 1'b0);
      tick(7);
      chk("wait.k8.done", bus.done_o, 1'b1);
      tick(1);
      chk("wait.end.en", bus.drive_en_o, 1'b0);

      // Abort: connect drops mid-K
      bus.resume_req_i = 1'b1;
      tick(1);
      bus.resume_req_i = 1'b0;
      tick(2);
      chk("abort.en_pre", bus.drive_en_o, 1'b1);
      bus.connect_req_i = 1'b0;
      tick(1);
      chk("abort.en",    bus.drive_en_o, 1'b0);
      chk("abort.dp_pu", bus.dp_pullup_en_o, 1'b0);
      chk("abort.err",   bus.err_o, 1'b1);
      chk("abort.done",  bus.done_o, 1'b0);
      chk("abort.busy",  bus.busy_o, 1'b0);
      tick(1);
      chk("abort.err2",  bus.err_o, 1'b0);
      bus.resume_req_i = 1'b1;
      tick(1);
      bus.resume_req_i = 1'b0;
      chk("disc.req.err", bus.err_o, 1'b1);
      chk("disc.req.en",  bus.drive_en_o, 1'b0);

      // Reconnect, then same-cycle resume + SE0: K wins, single err pulse
      bus.connect_req_i = 1'b1;
      tick(1);
      bus.resume_req_i = 1'b1;
      bus.se0_req_i    = 1'b1;
      tick(1);
      bus.resume_req_i = 1'b0;
      bus.se0_req_i    = 1'b0;
      chk_pins("both.k1", 1'b1, 1'b0, 1'b1, 1'b0);
      chk("both.err1", bus.err_o, 1'b1);
      tick(1);
      chk("both.err2", bus.err_o, 1'b0);

      // Pin flip while driving K swaps polarity on the next cycle
      bus.pin_flip_i = 1'b1;
      tick(1);
      chk_pins("flipk", 1'b1, 1'b1, 1'b0, 1'b0);
      bus.pin_flip_i = 1'b0;
      tick(1);

      // Async reset mid-pattern clears outputs before the next edge
      #2;
      rst = 1'b1;
      #1;
      chk_pins("arst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("arst.vbus", bus.vbus_valid_o, 1'b0);
      chk("arst.busy", bus.busy_o, 1'b0);
      chk("arst.done", bus.done_o, 1'b0);
      chk("arst.err",  bus.err_o,  1'b0);
      tick(2);
      rst = 1'b0;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
